// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter between NUM_REQ requesters.
// Round-robin arbitration with a bounded burst per requester; each captured
// byte is launched with a one-cycle tx_start and the arbiter waits for
// tx_done before choosing the next winner.
// Optional build macro UART_TX_ARB_TIMEOUT_EN adds a tx_done watchdog that
// abandons a byte after TIMEOUT_CYC cycles and pulses timeout_err; without it
// timeout_err is tied low and the arbiter waits for tx_done indefinitely.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GID_W       = 2,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_done,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  // Reject parameter sets the index arithmetic cannot support.
  if ((NUM_REQ != (1 << GID_W)) || (NUM_REQ < 2) || (NUM_REQ > 8) ||
      (MAX_BURST < 1) || (MAX_BURST > 15) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter combination");
  end

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } state_t;

  state_t           state;
  logic [GID_W-1:0] ptr;
  logic [3:0]       burst_cnt;
  logic [GID_W-1:0] winner;
  logic [7:0]       win_byte;

  // First requesting index at or above ptr, wrapping. NUM_REQ is a power of
  // two, so the GID_W-bit addition wraps modulo NUM_REQ on its own. The scan
  // runs downward so the closest index to ptr is the last one to assign.
  function automatic logic [GID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GID_W-1:0]   p);
    logic [GID_W-1:0] idx;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = p + GID_W'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner   = pick(req, ptr);
  assign win_byte = req_data[8*winner +: 8];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt;

  // Arbitration FSM with tx_done watchdog; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      burst_cnt   <= '0;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      req_ack     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            tx_byte  <= win_byte;
            req_ack  <= NUM_REQ'(1) << winner;
            grant_id <= winner;
            state    <= LAUNCH;
            // A nonzero count means the last grant ended as a burst continuation.
            if ((winner == grant_id) && (burst_cnt != 4'd0)) burst_cnt <= burst_cnt + 4'd1;
            else burst_cnt <= 4'd1;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b1;
          busy     <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // tx_done takes precedence over a watchdog expiring on the same edge.
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (req[grant_id] && (burst_cnt < MAX_B)) begin
              ptr <= grant_id;
            end else begin
              ptr       <= grant_id + GID_W'(1);
              burst_cnt <= 4'd0;
            end
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            ptr         <= grant_id + GID_W'(1);
            burst_cnt   <= 4'd0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  // Arbitration FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      burst_cnt <= '0;
      req_ack   <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      req_ack  <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            tx_byte  <= win_byte;
            req_ack  <= NUM_REQ'(1) << winner;
            grant_id <= winner;
            state    <= LAUNCH;
            // A nonzero count means the last grant ended as a burst continuation.
            if ((winner == grant_id) && (burst_cnt != 4'd0)) burst_cnt <= burst_cnt + 4'd1;
            else burst_cnt <= 4'd1;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b1;
          busy     <= 1'b1;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (req[grant_id] && (burst_cnt < MAX_B)) begin
              ptr <= grant_id;
            end else begin
              ptr       <= grant_id + GID_W'(1);
              burst_cnt <= 4'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: two instances (burst limit 4 and 1) driven
// by directed and randomized requester traffic, checked against a
// transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_s [2];
  logic [31:0] data_s [2];
  logic        done_s [2];
  logic [3:0]  ack_s [2];
  logic        start_s [2];
  logic [7:0]  byte_s [2];
  logic [1:0]  gid_s [2];
  logic        busy_s [2];
  logic        terr_s [2];

  int checks = 0;
  int failures = 0;

  // Reference model state: next scan origin, last winner, length of current run.
  int ptr_m [2];
  int gid_m [2];
  int run_m [2];
  int maxb [2] = '{4, 1};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .GID_W(2), .MAX_BURST(4), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .req_data(data_s[0]), .req_ack(ack_s[0]),
    .tx_start(start_s[0]), .tx_byte(byte_s[0]), .tx_done(done_s[0]), .grant_id(gid_s[0]),
    .busy(busy_s[0]), .timeout_err(terr_s[0]));

  uart_tx_arbiter #(.NUM_REQ(4), .GID_W(2), .MAX_BURST(1), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .req_data(data_s[1]), .req_ack(ack_s[1]),
    .tx_start(start_s[1]), .tx_byte(byte_s[1]), .tx_done(done_s[1]), .grant_id(gid_s[1]),
    .busy(busy_s[1]), .timeout_err(terr_s[1]));

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int scan(input int p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ptr_m[k] = 0; gid_m[k] = 0; run_m[k] = 0;
    end
  endtask

  // Requester side: a newly raised request comes with a fresh byte.
  task automatic set_req(input int k, input logic [3:0] nr);
    for (int i = 0; i < 4; i++) begin
      if (nr[i] && !req_s[k][i]) data_s[k][8*i +: 8] = 8'($urandom);
    end
    req_s[k] = nr;
  endtask

  task automatic idle_check(input string tag, input int k);
    check({tag, "_ack"}, k, 32'(ack_s[k]), 32'h0);
    check({tag, "_start"}, k, 32'(start_s[k]), 32'h0);
    check({tag, "_busy"}, k, 32'(busy_s[k]), 32'h0);
    check({tag, "_terr"}, k, 32'(terr_s[k]), 32'h0);
  endtask

  // One arbitration plus transfer; exp_w >= 0 also checks a fixed grant order.
  task automatic send_one(input int k, input int dly, input int exp_w, input bit keep, input bit churn);
    int w;
    logic [7:0] b;
    logic [3:0] rq;
    w = scan(ptr_m[k], req_s[k]);
    b = (w >= 0) ? data_s[k][8*w +: 8] : 8'h00;
    @(posedge clk); #1;
    if (w < 0) begin
      idle_check("noreq", k);
      return;
    end
    check("ack", k, 32'(ack_s[k]), 32'(4'b0001 << w));
    check("gid", k, 32'(gid_s[k]), 32'(w));
    check("byte", k, 32'(byte_s[k]), 32'(b));
    check("start_early", k, 32'(start_s[k]), 32'h0);
    check("busy_early", k, 32'(busy_s[k]), 32'h0);
    if (exp_w >= 0) check("order", k, 32'(gid_s[k]), 32'(exp_w));
    if (w == gid_m[k] && run_m[k] != 0) run_m[k]++;
    else run_m[k] = 1;
    gid_m[k] = w;
    data_s[k][8*w +: 8] = 8'($urandom);
    if (!keep) req_s[k][w] = 1'b0;
    done_s[k] = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    done_s[k] = 1'b0;
    check("start", k, 32'(start_s[k]), 32'h1);
    check("busy", k, 32'(busy_s[k]), 32'h1);
    check("ack_clr", k, 32'(ack_s[k]), 32'h0);
    check("byte_hold", k, 32'(byte_s[k]), 32'(b));
    for (int c = 0; c < dly; c++) begin
      if (churn) set_req(k, 4'($urandom));
      @(posedge clk); #1;
      check("inflight_busy", k, 32'(busy_s[k]), 32'h1);
      check("inflight_start", k, 32'(start_s[k]), 32'h0);
      check("inflight_terr", k, 32'(terr_s[k]), 32'h0);
    end
    rq = req_s[k];
    done_s[k] = 1'b1;
    @(posedge clk); #1;
    done_s[k] = 1'b0;
    if (rq[w] && run_m[k] < maxb[k]) begin
      ptr_m[k] = w;
    end else begin
      ptr_m[k] = (w + 1) % 4;
      run_m[k] = 0;
    end
    idle_check("done", k);
    check("byte_after", k, 32'(byte_s[k]), 32'(b));
  endtask

  int order_rr [5] = '{0, 1, 2, 3, 0};
  int order_bu [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int w;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 4'hF; data_s[k] = $urandom; done_s[k] = 1'b0;
    end
    model_reset();

    // Reset with all requests pending: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      idle_check("reset", k);
      check("reset_gid", k, 32'(gid_s[k]), 32'h0);
      check("reset_byte", k, 32'(byte_s[k]), 32'h0);
    end
    req_s[1] = 4'h0;
    rst_n = 1'b1;
    send_one(0, 2, 0, 1'b1, 1'b0);

    // Single request from requester 2.
    req_s[0] = 4'b0100;
    data_s[0][23:16] = 8'hA5;
    send_one(0, 5, 2, 1'b0, 1'b0);
    check("single_byte", 0, 32'(byte_s[0]), 32'hA5);

    // tx_done while idle is ignored.
    done_s[0] = 1'b1;
    @(posedge clk); #1;
    done_s[0] = 1'b0;
    idle_check("idle_done", 0);

    // Pure round-robin on the burst-limit-1 instance.
    set_req(1, 4'hF);
    for (int i = 0; i < 5; i++) send_one(1, 10, order_rr[i], 1'b1, 1'b0);
    req_s[1] = 4'h0;

    // Burst limit on a freshly reset instance.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    set_req(0, 4'b0011);
    for (int i = 0; i < 9; i++) send_one(0, 3, order_bu[i], 1'b1, 1'b0);
    req_s[0] = 4'b0001;
    for (int i = 0; i < 6; i++) send_one(0, 1, 0, 1'b1, 1'b0);

    // Reset three cycles after tx_start.
    set_req(0, 4'b0110);
    w = scan(ptr_m[0], req_s[0]);
    @(posedge clk); #1;
    check("mid_ack", 0, 32'(ack_s[0]), 32'(4'b0001 << w));
    @(posedge clk); #1;
    check("mid_start", 0, 32'(start_s[0]), 32'h1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    idle_check("mid_reset", 0);
    set_req(0, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    send_one(0, 1, 0, 1'b1, 1'b0);

    // Transmitter that never answers.
    set_req(0, 4'b1010);
    w = scan(ptr_m[0], req_s[0]);
    @(posedge clk); #1;
    check("to_gid", 0, 32'(gid_s[0]), 32'd1);
    run_m[0] = (w == gid_m[0] && run_m[0] != 0) ? run_m[0] + 1 : 1;
    gid_m[0] = w;
    @(posedge clk); #1;
    check("to_start", 0, 32'(start_s[0]), 32'h1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk); #1;
      check("to_terr", 0, 32'(terr_s[0]), (c == TO) ? 32'h1 : 32'h0);
      check("to_busy", 0, 32'(busy_s[0]), (c == TO) ? 32'h0 : 32'h1);
    end
    ptr_m[0] = (w + 1) % 4;
    run_m[0] = 0;
    send_one(0, 2, 3, 1'b1, 1'b0);
    check("to_pulse_end", 0, 32'(terr_s[0]), 32'h0);
`else
    for (int c = 1; c <= 3 * TO; c++) begin
      @(posedge clk); #1;
      check("noto_terr", 0, 32'(terr_s[0]), 32'h0);
      check("noto_busy", 0, 32'(busy_s[0]), 32'h1);
    end
    done_s[0] = 1'b1;
    @(posedge clk); #1;
    done_s[0] = 1'b0;
    if (req_s[0][w] && run_m[0] < maxb[0]) ptr_m[0] = w;
    else begin
      ptr_m[0] = (w + 1) % 4;
      run_m[0] = 0;
    end
    idle_check("noto_done", 0);
`endif

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 150; t++) begin
        if ($urandom_range(0, 7) == 0) begin
          set_req(k, 4'h0);
          done_s[k] = 1'b1;
          @(posedge clk); #1;
          done_s[k] = 1'b0;
          idle_check("rand_idle", k);
        end else begin
          if ($urandom_range(0, 1) == 0) set_req(k, 4'($urandom));
          send_one(k, $urandom_range(0, 4), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      set_req(k, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
